ahb_mem_slave: RTL and testbench

// - AHB-Lite slave backing a word-organised SRAM. It sits directly downstream of the bus master and

---
 rtl/ahb_pkg.sv | 41 ++++
 rtl/ahb_byte_strobe.sv | 19 +
 rtl/ahb_mem_slave.sv | 135 +++++++++++++
 tb/tb_ahb_mem_slave.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the memory slave's state enum.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // An access is illegal when out of range, wider than a word, or not naturally aligned.
  function automatic logic access_illegal(input logic [31:0] addr,
                                          input logic [2:0]  size,
                                          input logic [32:0] limit);
    logic bad;
    bad = ({1'b0, addr} >= limit) || (size > HSIZE_WORD);
    if ((size == HSIZE_HALF) && addr[0])
      bad = 1'b1;
    if ((size == HSIZE_WORD) && (addr[1:0] != 2'b00))
      bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane enables for a transfer of the given size at the given word offset.
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] lanes
);

  always_comb begin
    lanes = 4'b1111;
    case (size)
      HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
      HSIZE_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    lanes = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite slave in front of a word-organised SRAM with programmable wait states and a
// two-cycle ERROR response. DEPTH is expected to be a power of two.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  WAIT_LAST  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slave_state_e  state;
  logic [3:0]    wait_cnt;
  logic [AW+1:0] addr_q;
  logic [2:0]    size_q;
  logic          write_q;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          addr_err;
  logic          commit;
  logic          fwd_hit;
  logic [3:0]    lanes;
  logic [AW-1:0] widx_q;
  logic [AW-1:0] ridx;
  logic [31:0]   merged;
  logic [31:0]   rd_word;
  logic          unused_inputs;

  assign accept        = HSEL & HREADY & HTRANS[1];
  assign addr_err      = access_illegal(HADDR, HSIZE, ADDR_LIMIT);
  assign widx_q        = addr_q[AW+1:2];
  assign ridx          = HADDR[AW+1:2];
  assign commit        = (state == ST_DATA) && write_q;
  assign fwd_hit       = commit && (widx_q == ridx);
  assign unused_inputs = ^{HBURST, HTRANS[0]};

  ahb_byte_strobe u_strobe (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .lanes   (lanes)
  );

  // A read accepted while a write to the same word completes sees the post-write word.
  always_comb begin
    merged = mem[widx_q];
    for (int i = 0; i < 4; i++) begin
      if (lanes[i])
        merged[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  assign rd_word = fwd_hit ? merged : mem[ridx];

  always_ff @(posedge HCLK) begin
    for (int i = 0; i < 4; i++) begin
      if (commit && lanes[i])
        mem[widx_q][8*i +: 8] <= HWDATA[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      HRDATA    <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state     <= ST_DATA;
            wait_cnt  <= '0;
            HREADYOUT <= 1'b1;
            HRDATA    <= write_q ? '0 : mem[widx_q];
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        // IDLE, DATA and ERR2 are all points where a new address phase may be taken.
        default: begin
          state     <= ST_IDLE;
          wait_cnt  <= '0;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
          HRDATA    <= '0;
          if (accept) begin
            addr_q  <= HADDR[AW+1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
            if (addr_err) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state     <= ST_WAIT;
              HREADYOUT <= 1'b0;
            end else begin
              state <= ST_DATA;
              if (!HWRITE)
                HRDATA <= rd_word;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Scoreboard bench for ahb_mem_slave: two instances (0 and 3 wait states) share one driven
// bus; expected responses come from a byte-level reference memory per instance.
module tb_ahb_mem_slave;

  localparam int DEPTH     = 256;
  localparam int MEM_BYTES = DEPTH * 4;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          waits;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel;
  logic        hsel;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] rdata0, rdata1, hrdata;
  logic        rdy0, rdy1, resp0, resp1, hreadyout, hresp;

  exp_t        sb[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          dp_cycles    = 0;
  logic [7:0]  ref_mem [2][MEM_BYTES];

  assign hrdata    = sel ? rdata1 : rdata0;
  assign hreadyout = sel ? rdy1 : rdy0;
  assign hresp     = sel ? resp1 : resp0;

  ahb_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & ~sel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HREADY(rdy0), .HWDATA(hwdata),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  ahb_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & sel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HREADY(rdy1), .HWDATA(hwdata),
    .HRDATA(rdata1), .HREADYOUT(rdy1), .HRESP(resp1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  function automatic bit exp_illegal(input logic [31:0] a, input logic [2:0] s);
    return (a >= 32'(MEM_BYTES)) || (s > 3'd2) ||
           (s == 3'd1 && (a % 2) != 0) || (s == 3'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = int'(a) - int'(a % 4);
    return {ref_mem[sel][b+3], ref_mem[sel][b+2], ref_mem[sel][b+1], ref_mem[sel][b]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    for (int i = 0; i < (1 << s); i++) begin
      int b;
      b = int'(a) + i;
      ref_mem[sel][b] = 8'(d >> (8 * (b % 4)));
    end
  endtask

  task automatic wait_accept(input string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (hreadyout) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now(name);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] s,
                       input logic [1:0] tr, input logic [31:0] d, input bit apply);
    exp_t e;
    hsel = 1'b1; haddr = a; hwrite = wr; hsize = s; htrans = tr;
    wait_accept("accept_timeout");
    e.err   = exp_illegal(a, s);
    e.waits = e.err ? 0 : (sel ? 3 : 0);
    e.data  = (!wr && !e.err) ? model_word(a) : 32'h0;
    if (wr && !e.err && apply) model_write(a, s, d);
    sb.push_back(e);
    hwdata = d;
    htrans = TR_IDLE;
    hsel   = 1'b0;
  endtask

  task automatic bus_idle(input logic s_hsel, input logic [1:0] tr, input logic [31:0] a);
    hsel = s_hsel; htrans = tr; haddr = a; hwrite = 1'b1; hsize = 3'd2;
    wait_accept("idle_timeout");
    hwdata = $urandom;
    htrans = TR_IDLE;
    hsel   = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 80; n++) begin
      if (sb.size() == 0) return;
      @(posedge clk);
      #2;
    end
    fail_now("drain_timeout");
  endtask

  // Monitor: a data phase is open from an accepted NONSEQ/SEQ until the slave completes it.
  initial begin : monitor
    bit   dp;
    bit   saw_err1;
    int   waits;
    exp_t e;
    dp = 0; saw_err1 = 0; waits = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dp = 0; saw_err1 = 0; waits = 0;
        sb.delete();
        continue;
      end
      if (dp) begin
        dp_cycles++;
        if (sb.size() == 0) begin
          fail_now("scoreboard_empty");
          dp = 0;
        end else if (!hreadyout && !hresp) begin
          waits++;
          if (waits > 20) begin
            fail_now("wait_bound");
            void'(sb.pop_front());
            dp = 0; waits = 0;
          end
        end else if (!hreadyout && hresp) begin
          check("err1_resp", hresp, sb[0].err);
          saw_err1 = 1;
        end else begin
          e = sb.pop_front();
          check("resp", hresp, e.err);
          check("err1_seen", saw_err1, e.err);
          check("waits", waits, e.waits);
          check("rdata", hrdata, e.data);
          dp = 0; saw_err1 = 0; waits = 0;
        end
      end else begin
        check("idle_ready", hreadyout, 1'b1);
        check("idle_resp", hresp, 1'b0);
        check("idle_rdata", hrdata, 32'h0);
      end
      if (hreadyout && hsel && htrans[1]) dp = 1;
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    logic [31:0] a;
    logic [2:0]  s;
    int          r;
    int          snap;
    sel = 1'b0; hsel = 1'b0; haddr = '0; htrans = TR_IDLE; hwrite = 1'b0;
    hsize = 3'd2; hburst = 3'd0; hwdata = '0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      ref_mem[0][i] = 8'h0;
      ref_mem[1][i] = 8'h0;
    end

    #22;
    check("reset_ready0", rdy0, 1'b1);
    check("reset_resp0", resp0, 1'b0);
    check("reset_rdata0", rdata0, 32'h0);
    check("reset_ready1", rdy1, 1'b1);
    check("reset_resp1", resp1, 1'b0);
    check("reset_rdata1", rdata1, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Give every word the tests touch a known value in both memories.
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      for (int w = 0; w < 20; w++) begin
        a = (w < 16) ? 32'(w * 4) : 32'((252 + w - 16) * 4);
        issue(1'b1, a, 3'd2, TR_NONSEQ, $urandom, 1);
      end
      issue(1'b1, 32'h20, 3'd2, TR_NONSEQ, 32'h0, 1);
      drain();
    end

    sel = 1'b0;
    issue(1'b1, 32'h10, 3'd2, TR_NONSEQ, 32'hDEADBEEF, 1);
    issue(1'b0, 32'h10, 3'd2, TR_NONSEQ, $urandom, 1);
    issue(1'b1, 32'h21, 3'd0, TR_NONSEQ, 32'h00001200, 1);
    issue(1'b0, 32'h20, 3'd2, TR_NONSEQ, $urandom, 1);
    issue(1'b1, 32'h22, 3'd1, TR_NONSEQ, 32'hABCD0000, 1);
    issue(1'b0, 32'h20, 3'd2, TR_NONSEQ, $urandom, 1);
    issue(1'b1, 32'(MEM_BYTES), 3'd2, TR_NONSEQ, 32'hFFFFFFFF, 1);
    issue(1'b0, 32'h0, 3'd2, TR_NONSEQ, $urandom, 1);
    issue(1'b0, 32'h2, 3'd2, TR_NONSEQ, $urandom, 1);
    issue(1'b1, 32'h23, 3'd1, TR_NONSEQ, 32'h11111111, 1);
    issue(1'b1, 32'h24, 3'd3, TR_NONSEQ, 32'h22222222, 1);
    issue(1'b1, 32'h3FF, 3'd0, TR_NONSEQ, 32'h7E000000, 1);
    issue(1'b0, 32'h3FC, 3'd2, TR_NONSEQ, $urandom, 1);
    issue(1'b0, 32'h20, 3'd2, TR_NONSEQ, $urandom, 1);
    drain();

    // Burst with BUSY, deselected and IDLE cycles aimed at 0x3C, which must stay untouched.
    hburst = 3'd1;
    issue(1'b1, 32'h30, 3'd2, TR_NONSEQ, $urandom, 1);
    bus_idle(1'b1, TR_BUSY, 32'h3C);
    issue(1'b1, 32'h34, 3'd2, TR_SEQ, $urandom, 1);
    bus_idle(1'b0, TR_SEQ, 32'h3C);
    issue(1'b1, 32'h38, 3'd2, TR_SEQ, $urandom, 1);
    bus_idle(1'b1, TR_IDLE, 32'h3C);
    for (int w = 0; w < 4; w++) issue(1'b0, 32'(32'h30 + w * 4), 3'd2, TR_NONSEQ, 0, 1);
    drain();

    sel = 1'b1;
    issue(1'b0, 32'h10, 3'd2, TR_NONSEQ, $urandom, 1);
    drain();
    snap = dp_cycles;
    issue(1'b1, 32'h00, 3'd2, TR_NONSEQ, 32'h01020304, 1);
    issue(1'b1, 32'h04, 3'd2, TR_SEQ, 32'h05060708, 1);
    issue(1'b1, 32'h08, 3'd2, TR_SEQ, 32'h090A0B0C, 1);
    issue(1'b1, 32'h0C, 3'd2, TR_SEQ, 32'h0D0E0F10, 1);
    drain();
    check("burst_cycles", 32'(dp_cycles - snap), 32'd16);
    hburst = 3'd0;
    issue(1'b1, 32'h80, 3'd2, TR_NONSEQ, 32'h1, 1);
    issue(1'b0, 32'h04, 3'd2, TR_NONSEQ, $urandom, 1);
    issue(1'b0, 32'h02, 3'd2, TR_NONSEQ, $urandom, 1);
    drain();

    // Reset while the write to 0x30 is still in its wait states: the write must be lost.
    issue(1'b1, 32'h30, 3'd2, TR_NONSEQ, 32'h55AA55AA, 0);
    #3;
    check("wait_ready_low", hreadyout, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_async_ready", hreadyout, 1'b1);
    check("rst_async_resp", hresp, 1'b0);
    check("rst_async_rdata", hrdata, 32'h0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 32'h30, 3'd2, TR_NONSEQ, $urandom, 1);
    drain();

    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      for (int n = 0; n < 120; n++) begin
        if ($urandom_range(0, 9) == 0) begin
          r = $urandom_range(0, 2);
          bus_idle(r != 1, (r == 0) ? TR_BUSY : ((r == 1) ? TR_NONSEQ : TR_IDLE), 32'h3C);
        end else begin
          r = $urandom_range(0, 20);
          if (r < 16)      a = 32'(r * 4 + $urandom_range(0, 3));
          else if (r < 20) a = 32'((252 + r - 16) * 4 + $urandom_range(0, 3));
          else             a = 32'(MEM_BYTES + $urandom_range(0, 255));
          s = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
          issue($urandom_range(0, 1) == 1, a, s,
                ($urandom_range(0, 1) == 1) ? TR_SEQ : TR_NONSEQ, $urandom, 1);
        end
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
